// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master round-robin RAM arbiter with bounded lock bursts and wait states
module ram_arbiter #(
    parameter int DATAWIDTH   = 16,
    parameter int WAIT_STATES = 1,
    parameter int MAX_BURST   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_req,
    input  logic                 m1_req,
    input  logic                 m0_we,
    input  logic                 m1_we,
    input  logic                 m0_lock,
    input  logic                 m1_lock,
    input  logic [DATAWIDTH-1:0] m0_addr,
    input  logic [DATAWIDTH-1:0] m1_addr,
    input  logic [DATAWIDTH-1:0] m0_wdata,
    input  logic [DATAWIDTH-1:0] m1_wdata,
    output logic                 m0_ack,
    output logic                 m1_ack,
    output logic [DATAWIDTH-1:0] m0_rdata,
    output logic [DATAWIDTH-1:0] m1_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [DATAWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    input  logic [DATAWIDTH-1:0] ram_rdata,
    output logic                 busy,
    output logic                 owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [3:0]           burst_q, burst_d;
    logic [3:0]           wait_q, wait_d;
    logic                 we_q, we_d;
    logic [DATAWIDTH-1:0] addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATAWIDTH-1:0] rdata1_q, rdata1_d;

    logic own_req, own_lock, oth_req, grant_m;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        wait_d   = wait_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_m  = 1'b0;

        own_req  = owner_q ? m1_req  : m0_req;
        own_lock = owner_q ? m1_lock : m0_lock;
        oth_req  = owner_q ? m0_req  : m1_req;

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // A locking owner keeps the RAM until its burst budget runs out,
                    // but only while someone else is actually waiting.
                    if (own_req && own_lock && (burst_q < BURST_MAX || !oth_req)) begin
                        grant_m = owner_q;
                    end else if (m0_req && m1_req) begin
                        grant_m = !owner_q;
                    end else begin
                        grant_m = m1_req;
                    end
                    if (grant_m == owner_q) begin
                        burst_d = (burst_q < BURST_MAX) ? burst_q + 4'd1 : burst_q;
                    end else begin
                        burst_d = 4'd1;
                    end
                    owner_d = grant_m;
                    we_d    = grant_m ? m1_we    : m0_we;
                    addr_d  = grant_m ? m1_addr  : m0_addr;
                    wdata_d = grant_m ? m1_wdata : m0_wdata;
                    wait_d  = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    burst_d = 4'd0;
                end
            end
            S_ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    if (!we_q) begin
                        if (owner_q) rdata1_d = ram_rdata;
                        else         rdata0_d = ram_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b1;
            burst_q  <= 4'd0;
            wait_q   <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign ram_en    = (state_q == S_ACCESS);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_ack    = (state_q == S_DONE) && !owner_q;
    assign m1_ack    = (state_q == S_DONE) && owner_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - vector table plus scoreboard bench for ram_arbiter
module tb_ram_arbiter;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_v = '0, we_v = '0, lock_v = '0;
    logic [15:0] addr_v [2];
    logic [15:0] wdata_v [2];
    logic        ack0, ack1, ram_en, ram_we, busy, owner;
    logic [15:0] rd0, rd1, ram_addr, ram_wdata, ram_rdata;

    logic        d2_req = 1'b0;
    logic [15:0] d2_addr = '0;
    logic        d2_ack0, d2_ack1, d2_en, d2_we, d2_busy, d2_owner;
    logic [15:0] d2_rd0, d2_rd1, d2_ra, d2_rw, d2_rdata;

    logic [15:0] mem [256];
    bit          written [256];

    typedef struct {int m; bit we; logic [15:0] rd;} exp_t;
    typedef struct {int m; bit we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rd;} vec_t;
    exp_t exp_q[$];
    vec_t vt[7];

    int n_vec = 0, n_err = 0;
    int en_cnt = 0, we_cnt = 0;
    logic [15:0] a_first, last0, last1;

    always #5 clk = ~clk;

    ram_arbiter #(.DATAWIDTH(16), .WAIT_STATES(WS), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req_v[0]), .m1_req(req_v[1]),
        .m0_we(we_v[0]), .m1_we(we_v[1]),
        .m0_lock(lock_v[0]), .m1_lock(lock_v[1]),
        .m0_addr(addr_v[0]), .m1_addr(addr_v[1]),
        .m0_wdata(wdata_v[0]), .m1_wdata(wdata_v[1]),
        .m0_ack(ack0), .m1_ack(ack1),
        .m0_rdata(rd0), .m1_rdata(rd1),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    ram_arbiter #(.DATAWIDTH(16), .WAIT_STATES(0), .MAX_BURST(4)) dut_ws0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(d2_req), .m1_req(1'b0),
        .m0_we(1'b0), .m1_we(1'b0),
        .m0_lock(1'b0), .m1_lock(1'b0),
        .m0_addr(d2_addr), .m1_addr(16'h0000),
        .m0_wdata(16'h0000), .m1_wdata(16'h0000),
        .m0_ack(d2_ack0), .m1_ack(d2_ack1),
        .m0_rdata(d2_rd0), .m1_rdata(d2_rd1),
        .ram_en(d2_en), .ram_we(d2_we), .ram_addr(d2_ra), .ram_wdata(d2_rw),
        .ram_rdata(d2_rdata), .busy(d2_busy), .owner(d2_owner)
    );

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // RAM model: unwritten words read back a fixed address-derived pattern
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr[7:0]]     <= ram_wdata;
            written[ram_addr[7:0]] <= 1'b1;
        end
    end
    assign ram_rdata = written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : dflt(ram_addr);
    assign d2_rdata  = dflt(d2_ra);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0;
            we_cnt = 0;
            last0  = '0;
            last1  = '0;
        end else begin
            if (ram_en) begin
                if (en_cnt == 0) a_first = ram_addr;
                else check("addr_stable", ram_addr, a_first);
                en_cnt++;
                if (ram_we) we_cnt++;
            end
            if (ack0 || ack1) begin
                check("one_ack", {31'd0, ack0 && ack1}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    int m;
                    e = exp_q.pop_front();
                    m = ack1 ? 1 : 0;
                    check("ack_master", m, e.m);
                    check("owner", {31'd0, owner}, e.m);
                    check("en_cycles", en_cnt, WS + 1);
                    check("we_cycles", we_cnt, e.we ? WS + 1 : 0);
                    if (m == 0) begin
                        check("m0_rdata", rd0, e.we ? last0 : e.rd);
                        check("m1_rdata_hold", rd1, last1);
                    end else begin
                        check("m1_rdata", rd1, e.we ? last1 : e.rd);
                        check("m0_rdata_hold", rd0, last0);
                    end
                end
                last0  = rd0;
                last1  = rd1;
                en_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    task automatic run_master(input int m, input int n, input logic lk, input logic [15:0] base,
                              input logic w, input logic [15:0] wd, output int lat);
        bit got;
        lat = 0;
        for (int k = 0; k < n; k++) begin
            req_v[m]   = 1'b1;
            we_v[m]    = w;
            lock_v[m]  = lk;
            addr_v[m]  = base + 16'(k);
            wdata_v[m] = wd;
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if ((m == 0 && ack0) || (m == 1 && ack1)) begin
                    got = 1;
                    lat = c + 1;
                end
            end
            check("ack_seen", {31'd0, got}, 1);
        end
        req_v[m]  = 1'b0;
        lock_v[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1;
        vt[0] = '{0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        vt[1] = '{1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000};
        vt[2] = '{1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
        vt[3] = '{0, 1'b1, 16'h0030, 16'h5A5A, 16'h0000};
        vt[4] = '{1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A};
        vt[5] = '{0, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
        vt[6] = '{0, 1'b0, 16'h00FF, 16'h0000, 16'hA55A};
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;

        do_reset();
        check("rst_owner", {31'd0, owner}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ram_en", {31'd0, ram_en}, 0);
        check("rst_acks", {30'd0, ack1, ack0}, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_rdata", {rd1, rd0}, 0);

        foreach (vt[i]) begin
            exp_q.push_back('{vt[i].m, vt[i].we, vt[i].rd});
            run_master(vt[i].m, 1, 1'b0, vt[i].addr, vt[i].we, vt[i].wdata, lat);
            check("latency", lat, WS + 2);
            @(negedge clk);
        end

        // contention from reset: grants must alternate starting with m0
        do_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{0, 1'b0, dflt(16'h0040 + 16'(k))});
            exp_q.push_back('{1, 1'b0, dflt(16'h0050 + 16'(k))});
        end
        fork
            run_master(0, 2, 1'b0, 16'h0040, 1'b0, 16'h0000, lat0);
            run_master(1, 2, 1'b0, 16'h0050, 1'b0, 16'h0000, lat1);
        join
        @(negedge clk);

        // locked burst: m1 keeps 4, m0 gets one slot, m1 resumes
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back('{1, 1'b0, dflt(16'h0060 + 16'(k))});
        exp_q.push_back('{0, 1'b0, dflt(16'h0070)});
        for (int k = 4; k < 6; k++) exp_q.push_back('{1, 1'b0, dflt(16'h0060 + 16'(k))});
        exp_q.push_back('{0, 1'b0, dflt(16'h0071)});
        fork
            run_master(1, 6, 1'b1, 16'h0060, 1'b0, 16'h0000, lat1);
            run_master(0, 2, 1'b0, 16'h0070, 1'b0, 16'h0000, lat0);
        join
        @(negedge clk);

        // reset in the second ACCESS cycle of an m0 write
        do_reset();
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 16'h0080; wdata_v[0] = 16'h1111;
        @(negedge clk);
        check("mid_en_c1", {31'd0, ram_en}, 1);
        @(negedge clk);
        check("mid_en_c2", {31'd0, ram_we}, 1);
        rst_n = 1'b0;
        req_v[0] = 1'b0; we_v[0] = 1'b0;
        #1;
        check("mid_rst_en", {31'd0, ram_en}, 0);
        check("mid_rst_we", {31'd0, ram_we}, 0);
        check("mid_rst_ack", {30'd0, ack1, ack0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back('{1, 1'b0, dflt(16'h0090)});
        run_master(1, 1, 1'b0, 16'h0090, 1'b0, 16'h0000, lat);
        check("post_rst_latency", lat, WS + 2);
        @(negedge clk);

        // zero wait states on the second instance
        begin
            int en2, lat2;
            bit got2;
            en2 = 0; lat2 = 0; got2 = 0;
            d2_req = 1'b1; d2_addr = 16'h0010;
            for (int c = 0; c < 50 && !got2; c++) begin
                @(negedge clk);
                if (d2_en) en2++;
                if (d2_ack0) begin
                    got2 = 1;
                    lat2 = c + 1;
                end
            end
            d2_req = 1'b0;
            check("ws0_ack_seen", {31'd0, got2}, 1);
            check("ws0_latency", lat2, 2);
            check("ws0_en_cycles", en2, 1);
            check("ws0_rdata", d2_rd0, 16'h1234);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
